// File: rtl/si_tag_pkg.sv
// Shared tag types and channel-to-enable-bit mapping for the tag lane path.
package si_tag_pkg;

  typedef logic [63:0]        tag_time_t;
  typedef logic signed [5:0]  tag_channel_t;

  localparam int TTX_CHANNEL_COUNT = 20;

  // Enable-bit lookup result; index is meaningful only when valid is set.
  typedef struct packed {
    logic       valid;
    logic [5:0] index;
  } enable_index_t;

  // Rising channel +c maps to bit c-1, falling channel -c maps to bit
  // channel_count+c-1. Channel 0 and out-of-range magnitudes are invalid.
  function automatic enable_index_t channel_to_enable_index(
    input tag_channel_t channel,
    input int           channel_count = TTX_CHANNEL_COUNT
  );
    enable_index_t result;
    int            value;
    result = '0;
    value  = int'(channel);
    if (value > 0 && value <= channel_count) begin
      result.valid = 1'b1;
      result.index = 6'(value - 1);
    end else if (value < 0 && -value <= channel_count) begin
      result.valid = 1'b1;
      result.index = 6'(channel_count - value - 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/si_priority_pick.sv
// Lowest-set-bit picker: index, one-hot, non-empty and exactly-one flags.
module si_priority_pick #(
  parameter  int WIDTH   = 4,
  localparam int INDEX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]   mask,
  output logic [INDEX_W-1:0] index,
  output logic [WIDTH-1:0]   onehot,
  output logic               any,
  output logic               single
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    index  = '0;
    onehot = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index     = INDEX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign any    = |mask;
  // Exactly one bit set: nothing remains once the lowest bit is removed.
  assign single = any & ((mask & ~onehot) == '0);

endmodule

// File: rtl/si_tag_lane_serializer.sv
// Serializes filtered multi-lane tag bundles onto a single tag lane,
// lowest lane first, and counts the tags the channel filter drops.
module si_tag_lane_serializer
  import si_tag_pkg::*;
#(
  parameter int CHANNEL_COUNT   = TTX_CHANNEL_COUNT,
  parameter int NUMBER_OF_WORDS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  tag_time_t    [NUMBER_OF_WORDS-1:0]      s_axis_tagtime,
  input  tag_channel_t [NUMBER_OF_WORDS-1:0]      s_axis_channel,
  input  logic         [NUMBER_OF_WORDS-1:0]      s_axis_tkeep,
  input  logic         [2*CHANNEL_COUNT-1:0]      cfg_channel_enable,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output tag_time_t                               m_axis_tagtime,
  output tag_channel_t                            m_axis_channel,
  output logic                                    m_axis_tlast,
  output logic [31:0]                             stat_filtered
);

  localparam int IDX_W = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1;

  tag_time_t                   tagtime_reg [NUMBER_OF_WORDS];
  tag_channel_t                channel_reg [NUMBER_OF_WORDS];
  logic [NUMBER_OF_WORDS-1:0]  pending_reg;
  logic [31:0]                 stat_filtered_reg;

  logic [NUMBER_OF_WORDS-1:0]  enable_mask;
  logic [NUMBER_OF_WORDS-1:0]  dropped_mask;
  logic [3:0]                  drop_count;
  logic [32:0]                 stat_sum;
  logic [IDX_W-1:0]            pick_index;
  logic [NUMBER_OF_WORDS-1:0]  pick_onehot;
  logic                        pick_any;
  logic                        pick_single;
  logic                        accept;
  logic                        grant;

  // Per-lane filter: lane present and its channel enabled in the config.
  for (genvar gi = 0; gi < NUMBER_OF_WORDS; gi++) begin : g_lane_filter
    enable_index_t lane_index;
    assign lane_index       = channel_to_enable_index(s_axis_channel[gi], CHANNEL_COUNT);
    assign enable_mask[gi]  = s_axis_tkeep[gi] & lane_index.valid
                              & cfg_channel_enable[lane_index.index];
  end

  assign dropped_mask = s_axis_tkeep & ~enable_mask;

  // Count lanes that were present but rejected by the filter.
  always_comb begin
    drop_count = '0;
    for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
      drop_count = drop_count + {3'b000, dropped_mask[i]};
    end
  end

  assign stat_sum = {1'b0, stat_filtered_reg} + 33'(drop_count);

  si_priority_pick #(
    .WIDTH (NUMBER_OF_WORDS)
  ) u_pick (
    .mask   (pending_reg),
    .index  (pick_index),
    .onehot (pick_onehot),
    .any    (pick_any),
    .single (pick_single)
  );

  assign m_axis_tvalid  = pick_any;
  assign m_axis_tagtime = tagtime_reg[pick_index];
  assign m_axis_channel = channel_reg[pick_index];
  assign m_axis_tlast   = pick_single;
  assign stat_filtered  = stat_filtered_reg;

  // A new bundle may enter when empty or when the last pending tag leaves now.
  assign s_axis_tready = !rst & (!pick_any | (pick_single & m_axis_tready));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign grant         = m_axis_tvalid & m_axis_tready;

  // Pending mask and drop statistic; acceptance overrides the grant clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg       <= '0;
      stat_filtered_reg <= '0;
    end else if (accept) begin
      pending_reg       <= enable_mask;
      stat_filtered_reg <= stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
    end else if (grant) begin
      pending_reg       <= pending_reg & ~pick_onehot;
    end
  end

  // Bundle buffer captures all lanes on acceptance; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
        tagtime_reg[i] <= s_axis_tagtime[i];
        channel_reg[i] <= s_axis_channel[i];
      end
    end
  end

endmodule

// File: tb/tb_si_tag_lane_serializer.sv
// Directed bench for si_tag_lane_serializer with hand-computed expectations.
module tb_si_tag_lane_serializer;
  import si_tag_pkg::*;

  localparam int NW = 4;
  localparam int CC = TTX_CHANNEL_COUNT;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  tag_time_t    [NW-1:0]   s_axis_tagtime;
  tag_channel_t [NW-1:0]   s_axis_channel;
  logic         [NW-1:0]   s_axis_tkeep;
  logic         [2*CC-1:0] cfg_channel_enable;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  tag_time_t               m_axis_tagtime;
  tag_channel_t            m_axis_channel;
  logic                    m_axis_tlast;
  logic [31:0]             stat_filtered;

  int checks = 0;
  int errors = 0;

  si_tag_lane_serializer #(
    .CHANNEL_COUNT   (CC),
    .NUMBER_OF_WORDS (NW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tagtime     (s_axis_tagtime),
    .s_axis_channel     (s_axis_channel),
    .s_axis_tkeep       (s_axis_tkeep),
    .cfg_channel_enable (cfg_channel_enable),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tagtime     (m_axis_tagtime),
    .m_axis_channel     (m_axis_channel),
    .m_axis_tlast       (m_axis_tlast),
    .stat_filtered      (stat_filtered)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_bundle(input logic valid, input logic [NW-1:0] keep,
                            input int c0, input int c1, input int c2, input int c3,
                            input longint base);
    s_axis_tvalid     = valid;
    s_axis_tkeep      = keep;
    s_axis_channel[0] = tag_channel_t'(c0);
    s_axis_channel[1] = tag_channel_t'(c1);
    s_axis_channel[2] = tag_channel_t'(c2);
    s_axis_channel[3] = tag_channel_t'(c3);
    for (int i = 0; i < NW; i++) s_axis_tagtime[i] = tag_time_t'(base + i);
  endtask

  // Called at a falling edge with inputs already applied; checks, then
  // advances one full cycle back to the next falling edge.
  task automatic step(input string tag, input logic ev, input int ech,
                      input longint et, input logic elast, input logic erdy);
    #1;
    $display("txn %-8s m_valid=%0b ch=%0d time=%0d last=%0b s_ready=%0b stat=%h",
             tag, m_axis_tvalid, m_axis_channel, m_axis_tagtime, m_axis_tlast,
             s_axis_tready, stat_filtered);
    check({tag, ".m_valid"}, 64'(m_axis_tvalid), 64'(ev));
    if (ev) begin
      check({tag, ".channel"}, 64'($signed(m_axis_channel)), 64'(ech));
      check({tag, ".tagtime"}, m_axis_tagtime, 64'(et));
      check({tag, ".tlast"}, 64'(m_axis_tlast), 64'(elast));
    end
    check({tag, ".s_ready"}, 64'(s_axis_tready), 64'(erdy));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst                = 1'b1;
    cfg_channel_enable = '1;
    m_axis_tready      = 1'b1;
    set_bundle(1'b0, '0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.m_valid", 64'(m_axis_tvalid), 64'd0);
    check("reset.tlast", 64'(m_axis_tlast), 64'd0);
    check("reset.s_ready", 64'(s_axis_tready), 64'd0);
    check("reset.stat", 64'(stat_filtered), 64'd0);
    rst = 1'b0;

    // Basic bundle, tkeep 1011, then a back-to-back second bundle
    set_bundle(1'b1, 4'b1011, 3, -2, 7, 1, 100);
    step("t1_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    set_bundle(1'b1, 4'b0011, 5, 6, 0, 0, 200);
    step("t1_a", 1'b1, 3, 100, 1'b0, 1'b0);
    step("t1_b", 1'b1, -2, 101, 1'b0, 1'b0);
    step("t1_c", 1'b1, 1, 103, 1'b1, 1'b1);
    s_axis_tvalid = 1'b0;
    step("t1_d", 1'b1, 5, 200, 1'b0, 1'b0);
    step("t1_e", 1'b1, 6, 201, 1'b1, 1'b1);
    step("t1_idle", 1'b0, 0, 0, 1'b0, 1'b1);
    check("t1.stat", 64'(stat_filtered), 64'd0);

    // Consumer stalls 1,0,0,1,1
    set_bundle(1'b1, 4'b1011, 3, -2, 7, 1, 300);
    step("t2_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1; step("t2_c1", 1'b1, 3, 300, 1'b0, 1'b0);
    m_axis_tready = 1'b0; step("t2_c2", 1'b1, -2, 301, 1'b0, 1'b0);
    step("t2_c3", 1'b1, -2, 301, 1'b0, 1'b0);
    m_axis_tready = 1'b1; step("t2_c4", 1'b1, -2, 301, 1'b0, 1'b0);
    step("t2_c5", 1'b1, 1, 303, 1'b1, 1'b1);
    step("t2_idle", 1'b0, 0, 0, 1'b0, 1'b1);

    // Channel -2 disabled: only ch5 survives, three tags filtered
    cfg_channel_enable[CC + 1] = 1'b0;
    set_bundle(1'b1, 4'b1111, -2, -2, 5, -2, 400);
    step("t3_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    step("t3_a", 1'b1, 5, 402, 1'b1, 1'b1);
    step("t3_idle", 1'b0, 0, 0, 1'b0, 1'b1);
    check("t3.stat", 64'(stat_filtered), 64'd3);

    // Channel 0 and out-of-range magnitudes count as disabled
    set_bundle(1'b1, 4'b0111, 0, 21, -21, 1, 500);
    step("t3b_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    step("t3b_idle", 1'b0, 0, 0, 1'b0, 1'b1);
    check("t3b.stat", 64'(stat_filtered), 64'd6);

    // Empty bundle consumed in one cycle, no output, stat unchanged
    cfg_channel_enable = '1;
    set_bundle(1'b1, 4'b0000, 1, 1, 1, 1, 600);
    step("t4_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    step("t4_idle", 1'b0, 0, 0, 1'b0, 1'b1);
    check("t4.stat", 64'(stat_filtered), 64'd6);

    // Config change after acceptance does not affect buffered tags
    set_bundle(1'b1, 4'b0011, -2, -2, 0, 0, 700);
    step("t5_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    cfg_channel_enable[CC + 1] = 1'b0;
    step("t5_a", 1'b1, -2, 700, 1'b0, 1'b0);
    step("t5_b", 1'b1, -2, 701, 1'b1, 1'b1);
    cfg_channel_enable = '1;
    check("t5.stat", 64'(stat_filtered), 64'd6);

    // Reset with two tags pending
    set_bundle(1'b1, 4'b0111, 1, 2, 3, 0, 800);
    step("t6_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    step("t6_a", 1'b1, 1, 800, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst0.s_ready", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_rst1.m_valid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst1.s_ready", 64'(s_axis_tready), 64'd0);
    check("t6_rst1.stat", 64'(stat_filtered), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    step("t6_rel", 1'b0, 0, 0, 1'b0, 1'b1);
    step("t6_idle", 1'b0, 0, 0, 1'b0, 1'b1);

    // Saturation of the filter counter
    force dut.stat_filtered_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stat_filtered_reg;
    set_bundle(1'b1, 4'b0111, 0, 0, 0, 0, 900);
    step("t7_acc", 1'b0, 0, 0, 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
    step("t7_idle", 1'b0, 0, 0, 1'b0, 1'b1);
    check("t7.stat_sat", 64'(stat_filtered), 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
